multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Parametrised multicycle MIPS-subset control FSM for the IHW datapath. Drives every datapath mux and write-enable from opcode and funct. Stretches memory accesses by a configurable number of wait cycles and sequences multi-cycle mult/div. Handles invalid-instruction, overflow and divide-by-zero exceptions through EPC, a cause code and an exception vector.

Parameters:
MEM_WAIT, 1, extra cycles a memory read is held before data is valid (0..7)
MD_CYCLES, 32, cycles mult/div runs after md_start (2..63)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow
div_zero  in  1  divisor==0, valid in MD_START
pc_write  out  1  PC load enable
iord  out  1  0=PC, 1=ALUOut memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  0=rt, 1=rd
reg_write  out  1  regfile write
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=HI, 3=LO
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=4, 2=sext imm, 3=sext imm<<2
alu_op  out  2  0=add, 1=sub, 2=funct-decoded, 3=pass A
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector
epc_write  out  1  EPC load
cause  out  2  registered: 0=none, 1=invalid, 2=overflow, 3=div-by-zero
md_start  out  1  one-cycle mult/div start pulse
md_sel  out  1  0=mult, 1=div
hilo_write  out  1  HI/LO load
state_dbg  out  5  current state encoding

Behaviour:
- Reset (sync): state=RESET, cause=0, all outputs 0. RESET→FETCH after one cycle. Reset mid-instruction aborts: the next cycle asserts no write enable.
- Outputs are Moore decodes of state. Exception: pc_write in BRANCH = zero XOR (opcode==bne).
- FETCH: mem_read=1, iord=0. Wait counter loads MEM_WAIT on entry. On the cycle the count is 0: ir_write=1, pc_write=1, src_a=0, src_b=1, add, pc_source=0, then →DECODE. Fetch takes MEM_WAIT+1 cycles.
- DECODE: src_a=0, src_b=3, add (branch target into ALUOut). Dispatch:
  - R (0x00): add 20/sub 22/and 24/or 25/slt 2A→EXEC_R; jr 08→JR; mult 18/div 1A→MD_START; mfhi 10/mflo 12→MOVE_WB
  - addi 08→EXEC_I
  - lw 23/sw 2B→MEM_ADDR
  - beq 04/bne 05→BRANCH
  - j 02→JUMP
  - any other opcode or funct→EXC, cause=1
- EXEC_R: src_a=1, src_b=0, alu_op=2. If overflow and funct∈{add,sub}→EXC, cause=2; else→R_WB (reg_dst=1, reg_write=1, mem_to_reg=0)→FETCH.
- EXEC_I: src_a=1, src_b=2, add. Overflow→EXC, cause=2; else→I_WB (reg_dst=0, reg_write=1)→FETCH.
- MEM_ADDR: src_a=1, src_b=2, add. lw→MEM_READ; sw→MEM_WRITE.
- MEM_READ: iord=1, mem_read=1, waits MEM_WAIT cycles like FETCH→MEM_WB (reg_dst=0, mem_to_reg=1, reg_write=1)→FETCH.
- MEM_WRITE: iord=1, mem_write=1 for exactly one cycle→FETCH.
- BRANCH: src_a=1, src_b=0, sub, pc_source=1, conditional pc_write→FETCH.
- JUMP: pc_write=1, pc_source=2→FETCH.
- JR: src_a=1, alu_op=3, pc_source=0, pc_write=1→FETCH.
- MD_START: md_start=1, md_sel=(funct==1A). If div and div_zero→EXC, cause=3. Else counter loads MD_CYCLES-1→MD_RUN. MD_RUN decrements; at 0 hilo_write=1→FETCH.
- MOVE_WB: reg_dst=1, reg_write=1, mem_to_reg=2 (mfhi) or 3 (mflo)→FETCH.
- EXC: epc_write=1, pc_write=1, pc_source=3, no reg_write/hilo_write→FETCH. cause holds until the next exception or reset.
- MEM_WAIT=0: memory states last exactly one cycle.

Decomposition:
- ctrl_pkg: state enum (5-bit), opcode/funct localparams, mux-encoding localparams, cause codes.
- Sub-module ctrl_cycle_counter (6-bit load/decrement/zero flag), shared by memory wait and mult/div timing.

Test Plan:
- reset held 3 cycles mid-MD_RUN → all outputs 0; state_dbg=RESET, then FETCH; hilo_write never asserted.
- add (000000/0x20), overflow=0, MEM_WAIT=1 → FETCH 2 cycles, DECODE, EXEC_R, R_WB with reg_write=1, reg_dst=1; 5 cycles total.
- lw with MEM_WAIT=2 → mem_read high 3 consecutive cycles in MEM_READ with iord=1; MEM_WB mem_to_reg=1.
- beq with zero=1 → pc_write=1, pc_source=1; bne with zero=1 → pc_write=0.
- div with div_zero=1 → md_start pulse, next cycle EXC with epc_write=1, pc_source=3, cause=3, no hilo_write.
- opcode 0x3F → DECODE→EXC, cause=1; mult with MD_CYCLES=4 → hilo_write exactly 4 cycles after md_start.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller:
// state encoding, opcode/funct values, datapath mux codes, cause codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_EXEC_R    = 5'd3,
    S_R_WB      = 5'd4,
    S_EXEC_I    = 5'd5,
    S_I_WB      = 5'd6,
    S_MEM_ADDR  = 5'd7,
    S_MEM_READ  = 5'd8,
    S_MEM_WB    = 5'd9,
    S_MEM_WRITE = 5'd10,
    S_BRANCH    = 5'd11,
    S_JUMP      = 5'd12,
    S_JR        = 5'd13,
    S_MD_START  = 5'd14,
    S_MD_RUN    = 5'd15,
    S_MOVE_WB   = 5'd16,
    S_EXC       = 5'd17
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_MDR  = 2'd1;
  localparam logic [1:0] MTR_HI   = 2'd2;
  localparam logic [1:0] MTR_LO   = 2'd3;

  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FN   = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  localparam logic [1:0] PCS_ALU  = 2'd0;
  localparam logic [1:0] PCS_OUT  = 2'd1;
  localparam logic [1:0] PCS_JMP  = 2'd2;
  localparam logic [1:0] PCS_EXC  = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_INV  = 2'd1;
  localparam logic [1:0] CAUSE_OVF  = 2'd2;
  localparam logic [1:0] CAUSE_DIV0 = 2'd3;

endpackage

// File: rtl/ctrl_cycle_counter.sv
// 6-bit load/decrement counter with zero flag; times memory waits and mult/div.
// Ports: clk, reset, load, load_val[5:0], dec -> zero.
module ctrl_cycle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [5:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 6'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 6'd0) begin
      count <= count - 6'd1;
    end
  end

  assign zero = (count == 6'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore decode of every datapath control.
// Ports: clk, reset, opcode, funct, zero, overflow, div_zero -> mux/enables, cause, state_dbg.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT  = 1,
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       div_zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic [1:0] cause,
  output logic       md_start,
  output logic       md_sel,
  output logic       hilo_write,
  output logic [4:0] state_dbg
);

  localparam logic [5:0] MEM_LOAD = 6'(MEM_WAIT);
  localparam logic [5:0] MD_LOAD  = 6'(MD_CYCLES - 1);

  state_t     state;
  state_t     next;
  logic [1:0] cause_q;
  logic [1:0] next_cause;
  logic       cnt_zero;
  logic       cnt_load;
  logic       cnt_dec;
  logic [5:0] cnt_val;

  ctrl_cycle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    next       = state;
    next_cause = cause_q;
    unique case (state)
      S_RESET:  next = S_FETCH;
      S_FETCH:  if (cnt_zero) next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND,
              FN_OR, FN_SLT:     next = S_EXEC_R;
              FN_JR:             next = S_JR;
              FN_MULT, FN_DIV:   next = S_MD_START;
              FN_MFHI, FN_MFLO:  next = S_MOVE_WB;
              default: begin
                next       = S_EXC;
                next_cause = CAUSE_INV;
              end
            endcase
          end
          OP_ADDI:         next = S_EXEC_I;
          OP_LW, OP_SW:    next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  next = S_BRANCH;
          OP_J:            next = S_JUMP;
          default: begin
            next       = S_EXC;
            next_cause = CAUSE_INV;
          end
        endcase
      end
      S_EXEC_R: begin
        if (overflow && (funct == FN_ADD || funct == FN_SUB)) begin
          next       = S_EXC;
          next_cause = CAUSE_OVF;
        end else begin
          next = S_R_WB;
        end
      end
      S_EXEC_I: begin
        if (overflow) begin
          next       = S_EXC;
          next_cause = CAUSE_OVF;
        end else begin
          next = S_I_WB;
        end
      end
      S_MEM_ADDR: next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (cnt_zero) next = S_MEM_WB;
      S_MD_START: begin
        if (funct == FN_DIV && div_zero) begin
          next       = S_EXC;
          next_cause = CAUSE_DIV0;
        end else begin
          next = S_MD_RUN;
        end
      end
      S_MD_RUN: if (cnt_zero) next = S_FETCH;
      default:  next = S_FETCH;
    endcase
  end

  // The counter is reloaded only on entry to a timed state, never on its self-loop.
  always_comb begin
    cnt_load = (next != state) &&
               (next == S_FETCH || next == S_MEM_READ || next == S_MD_RUN);
    cnt_val  = (next == S_MD_RUN) ? MD_LOAD : MEM_LOAD;
    cnt_dec  = (state == S_FETCH || state == S_MEM_READ || state == S_MD_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= next;
      cause_q <= next_cause;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = MTR_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_source  = PCS_ALU;
    epc_write  = 1'b0;
    md_start   = 1'b0;
    md_sel     = 1'b0;
    hilo_write = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (cnt_zero) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_4;
        end
      end
      S_DECODE:   alu_src_b = SRCB_BR;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FN;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = MTR_MDR;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_OUT;
        // bne inverts the sense of the zero flag
        pc_write  = zero ^ (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JMP;
      end
      S_JR: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_PASS;
        pc_write  = 1'b1;
      end
      S_MD_START: begin
        md_start = 1'b1;
        md_sel   = (funct == FN_DIV);
      end
      S_MD_RUN:   hilo_write = cnt_zero;
      S_MOVE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (funct == FN_MFLO) ? MTR_LO : MTR_HI;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = PCS_EXC;
      end
      default: ;
    endcase
  end

  assign cause     = cause_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: reset, directed instruction table,
// reset abort during mult/div, and random instructions against a trace model.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int MW  = 2;
  localparam int MDC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow, div_zero;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, alu_src_a, epc_write;
  logic       md_start, md_sel, hilo_write;
  logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source, cause;
  logic [4:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT(MW), .MD_CYCLES(MDC)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .div_zero(div_zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .epc_write(epc_write), .cause(cause),
    .md_start(md_start), .md_sel(md_sel), .hilo_write(hilo_write),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       epc_write, md_start, md_sel, hilo_write;
    logic [1:0] cause;
  } out_t;

  out_t act;
  assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                pc_source, epc_write, md_start, md_sel, hilo_write, cause};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string nm, out_t a, out_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, a, e);
  endtask

  task automatic chk_int(string nm, int a, int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, a, e);
  endtask

  // ---------------- trace model ----------------
  out_t       exp_q[$];
  logic [1:0] m_cause;

  function automatic out_t blank();
    out_t o = '0;
    o.cause = m_cause;
    return o;
  endfunction

  task automatic push_exc(input logic [1:0] c);
    out_t o;
    m_cause     = c;
    o           = blank();
    o.epc_write = 1'b1;
    o.pc_write  = 1'b1;
    o.pc_source = 2'd3;
    exp_q.push_back(o);
  endtask

  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov, input logic dz);
    out_t o;
    bit   ralu, isdiv;
    exp_q.delete();
    for (int i = 0; i < MW; i++) begin
      o = blank(); o.mem_read = 1'b1; exp_q.push_back(o);
    end
    o = blank(); o.mem_read = 1'b1; o.ir_write = 1'b1;
    o.pc_write = 1'b1; o.alu_src_b = 2'd1; exp_q.push_back(o);
    o = blank(); o.alu_src_b = 2'd3; exp_q.push_back(o);
    ralu = (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
            fn == 6'h25 || fn == 6'h2A);
    isdiv = (fn == 6'h1A);
    if (op == 6'h00 && ralu) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_op = 2'd2; exp_q.push_back(o);
      if (ov && (fn == 6'h20 || fn == 6'h22)) push_exc(2'd2);
      else begin
        o = blank(); o.reg_dst = 1'b1; o.reg_write = 1'b1; exp_q.push_back(o);
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_op = 2'd3;
      o.pc_write = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h00 && (fn == 6'h18 || isdiv)) begin
      o = blank(); o.md_start = 1'b1; o.md_sel = isdiv; exp_q.push_back(o);
      if (isdiv && dz) push_exc(2'd3);
      else begin
        for (int i = 0; i < MDC - 1; i++) exp_q.push_back(blank());
        o = blank(); o.hilo_write = 1'b1; exp_q.push_back(o);
      end
    end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      o = blank(); o.reg_dst = 1'b1; o.reg_write = 1'b1;
      o.mem_to_reg = (fn == 6'h12) ? 2'd3 : 2'd2; exp_q.push_back(o);
    end else if (op == 6'h08) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; exp_q.push_back(o);
      if (ov) push_exc(2'd2);
      else begin
        o = blank(); o.reg_write = 1'b1; exp_q.push_back(o);
      end
    end else if (op == 6'h23) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; exp_q.push_back(o);
      for (int i = 0; i <= MW; i++) begin
        o = blank(); o.iord = 1'b1; o.mem_read = 1'b1; exp_q.push_back(o);
      end
      o = blank(); o.mem_to_reg = 2'd1; o.reg_write = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h2B) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; exp_q.push_back(o);
      o = blank(); o.iord = 1'b1; o.mem_write = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h04 || op == 6'h05) begin
      o = blank(); o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_source = 2'd1;
      o.pc_write = z ^ (op == 6'h05); exp_q.push_back(o);
    end else if (op == 6'h02) begin
      o = blank(); o.pc_write = 1'b1; o.pc_source = 2'd2; exp_q.push_back(o);
    end else begin
      push_exc(2'd1);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] op, fn;
    logic       z, ov, dz;
    int         len;
    logic [1:0] cse;
    logic [4:0] seen;   // {reg_write, mem_write, hilo_write, epc_write, iord&mem_read}
  } vec_t;

  vec_t tv[16];

  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[10];
    bit         done, left, hseen;
    int         n;
    logic [4:0] seen;

    tv[0]  = '{6'h00, 6'h20, 0, 0, 0, 6, 2'd0, 5'b10000};
    tv[1]  = '{6'h23, 6'h00, 0, 0, 0, 9, 2'd0, 5'b10001};
    tv[2]  = '{6'h2B, 6'h00, 0, 0, 0, 6, 2'd0, 5'b01000};
    tv[3]  = '{6'h04, 6'h00, 1, 0, 0, 5, 2'd0, 5'b00000};
    tv[4]  = '{6'h05, 6'h00, 1, 0, 0, 5, 2'd0, 5'b00000};
    tv[5]  = '{6'h02, 6'h00, 0, 0, 0, 5, 2'd0, 5'b00000};
    tv[6]  = '{6'h00, 6'h08, 0, 0, 0, 5, 2'd0, 5'b00000};
    tv[7]  = '{6'h00, 6'h18, 0, 0, 0, 9, 2'd0, 5'b00100};
    tv[8]  = '{6'h00, 6'h10, 0, 0, 0, 5, 2'd0, 5'b10000};
    tv[9]  = '{6'h00, 6'h20, 0, 1, 0, 6, 2'd2, 5'b00010};
    tv[10] = '{6'h00, 6'h1A, 0, 0, 1, 6, 2'd3, 5'b00010};
    tv[11] = '{6'h3F, 6'h00, 0, 0, 0, 5, 2'd1, 5'b00010};
    tv[12] = '{6'h08, 6'h00, 0, 1, 0, 6, 2'd2, 5'b00010};
    tv[13] = '{6'h00, 6'h22, 0, 0, 0, 6, 2'd2, 5'b10000};
    tv[14] = '{6'h00, 6'h3F, 0, 0, 0, 5, 2'd1, 5'b00010};
    tv[15] = '{6'h00, 6'h1A, 0, 0, 0, 9, 2'd1, 5'b00100};

    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12};

    reset = 1'b1; opcode = '0; funct = '0;
    zero = 1'b0; overflow = 1'b0; div_zero = 1'b0;
    tick(); tick();
    chk_out("reset_outs", act, '0);
    chk_int("reset_state", int'(state_dbg), int'(S_RESET));
    reset = 1'b0;
    tick();
    chk_int("first_fetch", int'(state_dbg), int'(S_FETCH));

    foreach (tv[r]) begin
      opcode = tv[r].op; funct = tv[r].fn;
      zero = tv[r].z; overflow = tv[r].ov; div_zero = tv[r].dz;
      seen = '0; n = 0; left = 0; done = 0;
      for (int k = 0; k < 64 && !done; k++) begin
        seen |= {reg_write, mem_write, hilo_write, epc_write, iord & mem_read};
        tick();
        n++;
        if (state_dbg != S_FETCH) left = 1;
        else if (left) done = 1;
      end
      chk_int($sformatf("tv%0d_len", r), done ? n : -1, tv[r].len);
      chk_int($sformatf("tv%0d_cause", r), int'(cause), int'(tv[r].cse));
      chk_int($sformatf("tv%0d_seen", r), int'(seen), int'(tv[r].seen));
    end

    // reset held three cycles while a mult is running
    opcode = 6'h00; funct = 6'h18; zero = 0; overflow = 0; div_zero = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (md_start) done = 1;
      else tick();
    end
    chk_int("md_start_seen", int'(done), 1);
    tick();
    reset = 1'b1; hseen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      hseen |= hilo_write;
      chk_out($sformatf("rst_md_outs%0d", k), act, '0);
      chk_int($sformatf("rst_md_state%0d", k), int'(state_dbg), int'(S_RESET));
    end
    reset = 1'b0;
    tick();
    hseen |= hilo_write;
    chk_int("rst_md_fetch", int'(state_dbg), int'(S_FETCH));
    chk_int("rst_md_no_hilo", int'(hseen), 0);
    m_cause = 2'd0;

    // random instructions against the trace model
    for (int t = 0; t < 150; t++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                       : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                       : fns[$urandom_range(0, 9)];
      if ($urandom_range(0, 2) == 0) op = 6'h00;
      opcode = op; funct = fn;
      zero = 1'($urandom); overflow = ($urandom_range(0, 3) == 0);
      div_zero = ($urandom_range(0, 2) == 0);
      model(op, fn, zero, overflow, div_zero);
      foreach (exp_q[c]) begin
        chk_out($sformatf("rnd%0d_op%h_fn%h_c%0d", t, op, fn, c), act, exp_q[c]);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
